// File: rtl/soc_bram_arb.sv
// Two-port arbiter in front of one soc_bram_ctl: registers the winning request, strobes the BRAM once, waits for ack or watchdog.
// Optional feature macro SOC_BRAM_ARB_RR_EN: round-robin tie-break instead of fixed p0 priority.
module soc_bram_arb #(
    parameter int addr_width = 8,
    parameter int timeout    = 15,
    parameter int tw         = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [addr_width-1:0] i_p0_addr,
    input  logic [31:0]           i_p0_dwrite,
    input  logic                  i_p0_rw,
    input  logic                  i_p0_stb,
    output logic [31:0]           o_p0_dread,
    output logic                  o_p0_ack,
    output logic                  o_p0_err,
    input  logic [addr_width-1:0] i_p1_addr,
    input  logic [31:0]           i_p1_dwrite,
    input  logic                  i_p1_rw,
    input  logic                  i_p1_stb,
    output logic [31:0]           o_p1_dread,
    output logic                  o_p1_ack,
    output logic                  o_p1_err,
    output logic [addr_width-1:0] o_mem_addr,
    output logic [31:0]           o_mem_dwrite,
    output logic                  o_mem_rw,
    output logic                  o_mem_stb,
    input  logic [31:0]           i_mem_dread,
    input  logic                  i_mem_ack,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [tw-1:0] wd_limit = tw'((timeout == 0) ? 0 : timeout - 1);

    state_t        state;
    state_t        state_next;
    logic          grant;
    logic          err_flag;
    logic [tw-1:0] watchdog;
    logic          any_req;
    logic          pick_p1;
    logic          wd_expired;

    assign any_req    = i_p0_stb || i_p1_stb;
    assign wd_expired = (timeout != 0) && (watchdog == wd_limit);

`ifdef SOC_BRAM_ARB_RR_EN
    // last_grant is 1 when p1 was served last; on a tie the other port wins.
    logic last_grant;

    assign pick_p1 = i_p1_stb && (!i_p0_stb || !last_grant);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= pick_p1;
        end
    end
`else
    assign pick_p1 = i_p1_stb && !i_p0_stb;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (i_mem_ack || wd_expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_mem_stb = (state == ISSUE);
    assign o_busy    = (state != IDLE);
    assign o_p0_ack  = (state == DONE) && !grant;
    assign o_p1_ack  = (state == DONE) && grant;
    assign o_p0_err  = o_p0_ack && err_flag;
    assign o_p1_err  = o_p1_ack && err_flag;

    // Request is latched only in IDLE; o_mem_* stay frozen through WAIT since the BRAM read mux uses addr[1:0].
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            grant        <= 1'b0;
            err_flag     <= 1'b0;
            watchdog     <= '0;
            o_mem_addr   <= '0;
            o_mem_dwrite <= '0;
            o_mem_rw     <= 1'b0;
            o_p0_dread   <= '0;
            o_p1_dread   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant        <= pick_p1;
                        err_flag     <= 1'b0;
                        o_mem_addr   <= pick_p1 ? i_p1_addr   : i_p0_addr;
                        o_mem_dwrite <= pick_p1 ? i_p1_dwrite : i_p0_dwrite;
                        o_mem_rw     <= pick_p1 ? i_p1_rw     : i_p0_rw;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    if (i_mem_ack) begin
                        if (grant) o_p1_dread <= i_mem_dread;
                        else       o_p0_dread <= i_mem_dread;
                    end else if (wd_expired) begin
                        err_flag <= 1'b1;
                        if (grant) o_p1_dread <= '0;
                        else       o_p0_dread <= '0;
                    end else begin
                        watchdog <= watchdog + tw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bram_arb.sv
// Scoreboard bench for soc_bram_arb: stimulus pushes expected acks and timed probes, a monitor compares them.
module tb_soc_bram_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_dwrite, p1_dwrite;
    logic        p0_rw, p1_rw, p0_stb, p1_stb;
    logic [31:0] p0_dread, p1_dread;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_dwrite, mem_dread;
    logic        mem_rw, mem_stb, mem_ack, busy;

    logic        ack_en;
    logic        done = 1'b0;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] mem [0:255];

    typedef struct {
        int          port;
        logic [31:0] dread;
        logic        err;
        int          cycle;
    } exp_t;

    // kind: 0 reset state, 1 issue strobe, 2 busy level, 3 strobe low
    typedef struct {
        int          cycle;
        int          kind;
        logic [31:0] value;
    } probe_t;

    exp_t   exp_q[$];
    probe_t probe_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    soc_bram_arb #(.addr_width(8), .timeout(15), .tw(4)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_p0_addr(p0_addr),
        .i_p0_dwrite(p0_dwrite),
        .i_p0_rw(p0_rw),
        .i_p0_stb(p0_stb),
        .o_p0_dread(p0_dread),
        .o_p0_ack(p0_ack),
        .o_p0_err(p0_err),
        .i_p1_addr(p1_addr),
        .i_p1_dwrite(p1_dwrite),
        .i_p1_rw(p1_rw),
        .i_p1_stb(p1_stb),
        .o_p1_dread(p1_dread),
        .o_p1_ack(p1_ack),
        .o_p1_err(p1_err),
        .o_mem_addr(mem_addr),
        .o_mem_dwrite(mem_dwrite),
        .o_mem_rw(mem_rw),
        .o_mem_stb(mem_stb),
        .i_mem_dread(mem_dread),
        .i_mem_ack(mem_ack),
        .o_busy(busy)
    );

    // BRAM stand-in: acks the cycle after a strobe, returns the word held before any write.
    initial begin
        logic        s_stb, s_rw;
        logic [7:0]  s_addr;
        logic [31:0] s_dw;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h05] = 32'hAABBCCDD;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hA0A00020;
        mem[8'h24] = 32'hA0A00024;
        mem[8'h28] = 32'hA0A00028;
        mem[8'h30] = 32'hB0B00030;
        mem[8'h34] = 32'hB0B00034;
        mem[8'h38] = 32'hB0B00038;
        mem[8'h40] = 32'hC0C00040;
        mem_ack   = 1'b0;
        mem_dread = 32'h0;
        forever begin
            @(negedge clk);
            s_stb  = mem_stb;
            s_addr = mem_addr;
            s_rw   = mem_rw;
            s_dw   = mem_dwrite;
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_dread = 32'h0;
            if (s_stb && ack_en) begin
                mem_ack   = 1'b1;
                mem_dread = mem[s_addr];
                if (s_rw) mem[s_addr] = s_dw;
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_ack(input int port);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_output($sformatf("unexpected_ack_p%0d", port), 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_output("ack_port", 64'(port), 64'(e.port));
            check_output("ack_dread", port == 1 ? p1_dread : p0_dread, e.dread);
            check_output("ack_err", port == 1 ? p1_err : p0_err, e.err);
            if (e.cycle >= 0) check_output("ack_cycle", 64'(cyc), 64'(e.cycle));
        end
    endtask

    // Monitor owns every comparison and the summary.
    initial begin
        probe_t p;
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0 && probe_q[0].cycle <= cyc) begin
                p = probe_q.pop_front();
                case (p.kind)
                    0: begin
                        check_output("reset_ctrl", {p0_ack, p1_ack, p0_err, p1_err, mem_stb, busy}, 64'd0);
                        check_output("reset_dread", {p0_dread, p1_dread}, 64'd0);
                    end
                    1: check_output("issue", {mem_stb, mem_rw, mem_addr}, {1'b1, p.value[8:0]});
                    2: check_output("busy", busy, p.value[0]);
                    default: check_output("stb_one_cycle", mem_stb, 64'd0);
                endcase
            end
            check_output("ack_exclusive", p0_ack & p1_ack, 64'd0);
            if (p0_ack) check_ack(0);
            if (p1_ack) check_ack(1);
            if (done || cyc > 5000) begin
                if (!done) check_output("run_timeout", 64'd1, 64'd0);
                check_output("pending_acks", 64'(exp_q.size()), 64'd0);
                check_output("pending_probes", 64'(probe_q.size()), 64'd0);
                $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
                $finish;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input int port, input logic [7:0] addr, input logic rw, input logic [31:0] dw);
        if (port == 0) begin
            p0_addr = addr; p0_rw = rw; p0_dwrite = dw; p0_stb = 1'b1;
        end else begin
            p1_addr = addr; p1_rw = rw; p1_dwrite = dw; p1_stb = 1'b1;
        end
    endtask

    task automatic release_port(input int port);
        if (port == 0) p0_stb = 1'b0;
        else           p1_stb = 1'b0;
    endtask

    task automatic expect_ack(input int port, input logic [31:0] dread, input logic err, input int cycle);
        exp_t e;
        e.port = port; e.dread = dread; e.err = err; e.cycle = cycle;
        exp_q.push_back(e);
    endtask

    task automatic add_probe(input int cycle, input int kind, input logic [31:0] value);
        probe_t p;
        p.cycle = cycle; p.kind = kind; p.value = value;
        probe_q.push_back(p);
    endtask

    task automatic wait_for_ack(input int port, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) seen = 1'b1;
        end
        release_port(port);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        add_probe(cyc, 0, 32'h0);
    endtask

    initial begin
        int          c;
        int          idx0;
        int          idx1;
        logic [7:0]  p0_list [3];
        logic [7:0]  p1_list [3];
        logic [31:0] p0_data [3];
        logic [31:0] p1_data [3];
        p0_list = '{8'h20, 8'h24, 8'h28};
        p1_list = '{8'h30, 8'h34, 8'h38};
        p0_data = '{32'hA0A00020, 32'hA0A00024, 32'hA0A00028};
        p1_data = '{32'hB0B00030, 32'hB0B00034, 32'hB0B00038};
        reset = 1'b1;
        ack_en = 1'b1;
        p0_addr = 8'h0; p0_dwrite = 32'h0; p0_rw = 1'b0; p0_stb = 1'b0;
        p1_addr = 8'h0; p1_dwrite = 32'h0; p1_rw = 1'b0; p1_stb = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        add_probe(cyc, 0, 32'h0);
        wait_cycles(1);

        $display("[TB] T1 single read");
        c = cyc;
        apply_stimulus(0, 8'h05, 1'b0, 32'h0);
        add_probe(c + 1, 1, {23'h0, 1'b0, 8'h05});
        add_probe(c + 2, 3, 32'h0);
        expect_ack(0, 32'hAABBCCDD, 1'b0, c + 3);
        add_probe(c + 4, 2, 32'h0);
        wait_for_ack(0, 30);
        wait_cycles(1);

        $display("[TB] T2 p1 write then read");
        c = cyc;
        apply_stimulus(1, 8'h10, 1'b1, 32'h12345678);
        add_probe(c + 1, 1, {23'h0, 1'b1, 8'h10});
        expect_ack(1, 32'hDEADBEEF, 1'b0, c + 3);
        wait_for_ack(1, 30);
        wait_cycles(1);
        c = cyc;
        apply_stimulus(1, 8'h10, 1'b0, 32'h0);
        expect_ack(1, 32'h12345678, 1'b0, c + 3);
        wait_for_ack(1, 30);
        wait_cycles(1);

        $display("[TB] T3/T4 tie arbitration");
        pulse_reset();
        wait_cycles(1);
        c = cyc;
`ifdef SOC_BRAM_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
            expect_ack(0, p0_data[k], 1'b0, c + 3 + 8 * k);
            expect_ack(1, p1_data[k], 1'b0, c + 7 + 8 * k);
        end
`else
        for (int k = 0; k < 3; k++) expect_ack(0, p0_data[k], 1'b0, c + 3 + 4 * k);
        for (int k = 0; k < 3; k++) expect_ack(1, p1_data[k], 1'b0, c + 15 + 4 * k);
`endif
        idx0 = 0;
        idx1 = 0;
        apply_stimulus(0, p0_list[0], 1'b0, 32'h0);
        apply_stimulus(1, p1_list[0], 1'b0, 32'h0);
        for (int i = 0; i < 60 && (idx0 < 3 || idx1 < 3); i++) begin
            @(posedge clk);
            #1;
            if (p0_ack && idx0 < 3) begin
                idx0++;
                if (idx0 < 3) apply_stimulus(0, p0_list[idx0], 1'b0, 32'h0);
                else          release_port(0);
            end
            if (p1_ack && idx1 < 3) begin
                idx1++;
                if (idx1 < 3) apply_stimulus(1, p1_list[idx1], 1'b0, 32'h0);
                else          release_port(1);
            end
        end
        release_port(0);
        release_port(1);
        wait_cycles(1);

        $display("[TB] T5 watchdog");
        ack_en = 1'b0;
        c = cyc;
        apply_stimulus(0, 8'h40, 1'b0, 32'h0);
        add_probe(c + 16, 2, 32'h1);
        expect_ack(0, 32'h0, 1'b1, c + 17);
        add_probe(c + 18, 2, 32'h0);
        wait_for_ack(0, 40);
        wait_cycles(1);
        ack_en = 1'b1;

        $display("[TB] T6 reset during WAIT");
        ack_en = 1'b0;
        c = cyc;
        apply_stimulus(1, 8'h34, 1'b0, 32'h0);
        add_probe(c + 3, 2, 32'h1);
        wait_cycles(4);
        release_port(1);
        pulse_reset();
        wait_cycles(25);
        ack_en = 1'b1;
        c = cyc;
        apply_stimulus(1, 8'h34, 1'b0, 32'h0);
        expect_ack(1, 32'hB0B00034, 1'b0, c + 3);
        wait_for_ack(1, 30);
        wait_cycles(2);
        done = 1'b1;
    end

endmodule
